char_readout_tx: RTL and testbench

- Transmit side of the characterization results path.
- Takes one completed measurement word (e.g. a ring-oscillator frequency count) plus a 4-bit source ID from the measurement core.
- Serialises it as a byte-wide frame onto the dedicated output pins, using a four-phase strobe/ack handshake with the external tester.
- Sits between the measurement counters and uo_out; the ack input arrives on a uio input pin.

---
 rtl/char_readout_tx.sv | 160 ++++++++++++++++
 tb/tb_char_readout_tx.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/char_readout_tx.sv
// char_readout_tx: serialises one measurement word plus its source ID as a byte-wide frame
// (header {4'hA, id}, payload MSB first) using a four-phase strobe/ack handshake with an
// external tester. The tester's ack is asynchronous and passes through a synchroniser.
// Optional build macro CHARACTERIZATION_CHECKSUM_EN appends an XOR checksum byte covering
// the header and all payload bytes.
module char_readout_tx #(
    parameter int unsigned DATA_BYTES     = 4,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    result_valid,
    output logic                    result_ready,
    input  logic [8*DATA_BYTES-1:0] result_data,
    input  logic [3:0]              result_id,
    output logic [7:0]              tx_data,
    output logic                    tx_strobe,
    input  logic                    tx_ack,
    output logic                    busy,
    output logic                    timeout_err,
    input  logic                    clear_err
);

    localparam int unsigned DW = 8 * DATA_BYTES;
`ifdef CHARACTERIZATION_CHECKSUM_EN
    localparam logic [3:0] LastIdx = 4'(DATA_BYTES + 1);
`else
    localparam logic [3:0] LastIdx = 4'(DATA_BYTES);
`endif
    localparam logic [3:0]  LastPayload = 4'(DATA_BYTES);
    localparam logic        TmoEn       = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TmoLast     = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StPresent, StRelease} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_s;
    logic                   armed_q, armed_d;
    logic [3:0]             idx_q, idx_d;
    logic [DW-1:0]          shift_q, shift_d;
    logic [7:0]             data_q, data_d;
    logic                   strobe_q, strobe_d;
    logic [15:0]            cnt_q, cnt_d;
    logic                   err_q, err_d;
`ifdef CHARACTERIZATION_CHECKSUM_EN
    logic [7:0]             csum_q, csum_d;
`endif

    logic capture, tmo_hit, advance, released, last_byte;

    assign ack_s     = sync_q[SYNC_STAGES-1];
    assign capture   = (state_q == StIdle) && result_valid;
    assign tmo_hit   = TmoEn && (state_q != StIdle) && (cnt_q == TmoLast);
    // Advance only on a fresh ack rise seen while the strobe is actually up, so a stale or
    // early ack can never consume a byte.
    assign advance   = (state_q == StPresent) && strobe_q && ack_s && armed_q;
    assign released  = (state_q == StRelease) && !ack_s;
    assign last_byte = (idx_q >= LastIdx);

    // State and datapath registers, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            sync_q   <= '0;
            armed_q  <= 1'b0;
            idx_q    <= '0;
            shift_q  <= '0;
            data_q   <= 8'h00;
            strobe_q <= 1'b0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
`ifdef CHARACTERIZATION_CHECKSUM_EN
            csum_q   <= 8'h00;
`endif
        end else begin
            state_q  <= state_d;
            sync_q   <= {sync_q[SYNC_STAGES-2:0], tx_ack};
            armed_q  <= armed_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`ifdef CHARACTERIZATION_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (capture) state_d = StPresent;
            end
            StPresent: begin
                if (tmo_hit || idx_q > LastIdx) state_d = StIdle;
                else if (advance)               state_d = StRelease;
            end
            StRelease: begin
                if (tmo_hit)       state_d = StIdle;
                else if (released) state_d = last_byte ? StIdle : StPresent;
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath next values: byte loading, ack arming, timeout counter, sticky error
    always_comb begin
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
`ifdef CHARACTERIZATION_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        // Any ack_s low re-arms; an ack_s high seen in idle is stale and disarms.
        armed_d  = !ack_s ? 1'b1 : ((state_q == StIdle) ? 1'b0 : armed_q);
        // Strobe lags state entry by a cycle so tx_data is set up before it rises.
        strobe_d = (state_q == StPresent) && (state_d == StPresent);
        cnt_d    = (state_q == StIdle || state_d != state_q) ? 16'd0 : cnt_q + 16'd1;
        // Timeout set wins over a simultaneous clear.
        err_d    = tmo_hit ? 1'b1 : (clear_err ? 1'b0 : err_q);

        if (capture) begin
            idx_d   = 4'd0;
            shift_d = result_data;
            data_d  = {4'hA, result_id};
`ifdef CHARACTERIZATION_CHECKSUM_EN
            csum_d  = {4'hA, result_id};
`endif
        end else if (tmo_hit) begin
            data_d = 8'h00;
        end else if (released && !last_byte) begin
            idx_d = idx_q + 4'd1;
            if (idx_q < LastPayload) begin
                data_d  = shift_q[DW-1 -: 8];
                shift_d = shift_q << 8;
`ifdef CHARACTERIZATION_CHECKSUM_EN
                csum_d  = csum_q ^ shift_q[DW-1 -: 8];
            end else begin
                data_d  = csum_q;
`endif
            end
        end
    end

    // Outputs
    always_comb begin
        result_ready = (state_q == StIdle);
        busy         = (state_q != StIdle);
        tx_data      = data_q;
        tx_strobe    = strobe_q;
        timeout_err  = err_q;
    end

endmodule

// File: tb/tb_char_readout_tx.sv
module tb_char_readout_tx;

`ifdef CHARACTERIZATION_CHECKSUM_EN
    localparam int ExpLen = 6;
`else
    localparam int ExpLen = 5;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        result_valid = 1'b0;
    logic        result_ready;
    logic [31:0] result_data = '0;
    logic [3:0]  result_id = '0;
    logic [7:0]  tx_data;
    logic        tx_strobe;
    logic        tx_ack = 1'b0;
    logic        busy;
    logic        timeout_err;
    logic        clear_err = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    logic [7:0] got [8];
    logic [7:0] pre [8];
    bit         hold [8];
    logic [7:0] pre_edge_data;
    int         nb;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        int          dly;
        logic [47:0] exp;   // header, 4 payload bytes, checksum
    } vec_t;

    char_readout_tx #(
        .DATA_BYTES    (4),
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .result_data (result_data),
        .result_id   (result_id),
        .tx_data     (tx_data),
        .tx_strobe   (tx_strobe),
        .tx_ack      (tx_ack),
        .busy        (busy),
        .timeout_err (timeout_err),
        .clear_err   (clear_err)
    );

    always #5 clk = ~clk;

    // tx_data as it was during the cycle before each rising edge
    always @(posedge clk) pre_edge_data = tx_data;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: act=still running req=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: act=%0h req=%0h", name, act, exp);
        end
    endtask

    task automatic start_frame(input logic [3:0] id, input logic [31:0] d);
        int w;
        w = 0;
        while (!result_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("ready_before_capture", result_ready, 1);
        result_id    = id;
        result_data  = d;
        result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
        result_id    = ~id;
        result_data  = ~d;
    endtask

    // Tester model: acks each strobe after dly cycles. Stops when the block returns to idle
    // or, with strobe still high, after stop_after bytes.
    task automatic tester(input int dly, input int stop_after, output int n);
        int w;
        bit done;
        bit stable;
        n = 0;
        done = 0;
        while (!done) begin
            w = 0;
            while (!tx_strobe && !result_ready && w < 100) begin
                @(negedge clk);
                w++;
            end
            if (w >= 100) begin
                chk("wait_strobe_bound", 0, 1);
                done = 1;
            end else if (tx_strobe) begin
                if (n < 8) begin
                    got[n] = tx_data;
                    pre[n] = pre_edge_data;
                end
                n++;
                if (n == stop_after) begin
                    done = 1;
                end else begin
                    stable = 1;
                    repeat (dly) begin
                        @(negedge clk);
                        if (!tx_strobe || tx_data !== got[(n-1)%8]) stable = 0;
                    end
                    tx_ack = 1'b1;
                    w = 0;
                    while (tx_strobe && w < 100) begin
                        @(negedge clk);
                        w++;
                        if (tx_data !== got[(n-1)%8]) stable = 0;
                    end
                    if (w >= 100) begin
                        chk("wait_strobe_fall_bound", 0, 1);
                        done = 1;
                    end
                    if (n <= 8) hold[n-1] = stable;
                    tx_ack = 1'b0;
                    @(negedge clk);
                end
            end else begin
                done = 1;
            end
        end
    endtask

    task automatic check_frame(input string tag, input logic [47:0] exp, input int n);
        chk({tag, "_len"}, n, ExpLen);
        for (int i = 0; i < ExpLen && i < n; i++) begin
            chk($sformatf("%s_byte%0d", tag, i), got[i], exp[47-8*i -: 8]);
            chk($sformatf("%s_setup%0d", tag, i), pre[i], exp[47-8*i -: 8]);
            chk($sformatf("%s_hold%0d", tag, i), hold[i], 1);
        end
        chk({tag, "_idle"}, {busy, result_ready}, 2'b01);
    endtask

    vec_t vecs [4];

    initial begin
        vecs[0] = '{id: 4'h3, data: 32'h1234_5678, dly: 5, exp: 48'hA3_12_34_56_78_AB};
        vecs[1] = '{id: 4'h5, data: 32'hDEAD_BEEF, dly: 2, exp: 48'hA5_DE_AD_BE_EF_87};
        vecs[2] = '{id: 4'h0, data: 32'h0000_0000, dly: 0, exp: 48'hA0_00_00_00_00_A0};
        vecs[3] = '{id: 4'hF, data: 32'hFF00_FF01, dly: 6, exp: 48'hAF_FF_00_FF_01_AE};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_strobe", tx_strobe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", result_ready, 1);
        chk("rst_err", timeout_err, 0);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven frames
        for (int v = 0; v < 4; v++) begin
            start_frame(vecs[v].id, vecs[v].data);
            chk($sformatf("v%0d_busy_after_capture", v), {busy, result_ready}, 2'b10);
            tester(vecs[v].dly, 99, nb);
            check_frame($sformatf("v%0d", v), vecs[v].exp, nb);
        end

        // Back-pressure: second word held valid while busy
        start_frame(4'h3, 32'h1234_5678);
        result_valid = 1'b1;
        result_id    = 4'h5;
        result_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("bp_not_ready", result_ready, 0);
        tester(3, 99, nb);
        check_frame("bp_first", 48'hA3_12_34_56_78_AB, nb);
        @(negedge clk);
        result_valid = 1'b0;
        chk("bp_second_captured", busy, 1);
        tester(2, 99, nb);
        check_frame("bp_second", 48'hA5_DE_AD_BE_EF_87, nb);

        // Reset mid-frame while the fourth byte is strobed
        start_frame(4'h7, 32'h0102_0304);
        tester(1, 4, nb);
        chk("midrst_byte3", got[3], 8'h03);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_strobe", tx_strobe, 0);
        chk("midrst_data", tx_data, 8'h00);
        chk("midrst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        start_frame(4'h9, 32'hCAFE_F00D);
        tester(1, 99, nb);
        check_frame("after_rst", 48'hA9_CA_FE_F0_0D_60, nb);

        // Stale ack: ack already high at capture must not advance the header
        tx_ack = 1'b1;
        repeat (4) @(negedge clk);
        start_frame(4'h6, 32'h89AB_CDEF);
        repeat (5) @(negedge clk);
        chk("stale_strobe_a", tx_strobe, 1);
        chk("stale_data_a", tx_data, 8'hA6);
        tx_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("stale_strobe_b", tx_strobe, 1);
        chk("stale_data_b", tx_data, 8'hA6);
        tester(0, 99, nb);
        // A6^89=2F, ^AB=84, ^CD=49, ^EF=A6
        check_frame("stale", 48'hA6_89_AB_CD_EF_A6, nb);

        // Timeout with no ack: 16 cycles after capture the frame aborts
        start_frame(4'h3, 32'h1234_5678);
        repeat (15) @(negedge clk);
        chk("tmo_before_strobe", tx_strobe, 1);
        chk("tmo_before_err", timeout_err, 0);
        @(negedge clk);
        chk("tmo_strobe", tx_strobe, 0);
        chk("tmo_data", tx_data, 8'h00);
        chk("tmo_err", timeout_err, 1);
        chk("tmo_idle", {busy, result_ready}, 2'b01);
        repeat (3) @(negedge clk);
        chk("tmo_err_sticky", timeout_err, 1);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        chk("tmo_cleared", timeout_err, 0);

        // Timeout coinciding with clear_err: set wins
        start_frame(4'h2, 32'h5555_AAAA);
        clear_err = 1'b1;
        repeat (16) @(negedge clk);
        chk("tmo_set_wins", timeout_err, 1);
        clear_err = 1'b0;
        @(negedge clk);
        chk("tmo_set_wins_hold", timeout_err, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
